// File: rtl/text_console_pkg.sv
// text_console_pkg
//   Shared definitions for the text console writer and its cursor block.
//   - FSM state encoding for the writer
//   - Control code constants (CR, LF, BS, FF)
//   - Address/column/row widths of the 32x32 text buffer
//   - buf_addr(): packs {row, col} into a text buffer address
package text_console_pkg;

    localparam int ADDR_W = 10;
    localparam int COL_W  = 5;
    localparam int ROW_W  = 5;

    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_FF = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_NEWLINE_CLR,
        ST_BACKSPACE,
        ST_CLEAR_ALL
    } state_t;

    function automatic logic [ADDR_W-1:0] buf_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/text_console_cursor.sv
// text_console_cursor
//   Cursor and scroll state for the text console writer.
//   Ports:
//     i_pix_clk, i_reset_n   clock, asynchronous active-low reset
//     inc_col / dec_col      move cursor one column right / left (wraps mod 32)
//     cr                     column back to 0
//     newline                column 0, next physical row; scrolls once the
//                            visible row reaches the bottom of the screen
//     home                   cursor, visible row and top row all to 0
//     col, phys_row          cursor position in the buffer
//     vis_row                cursor row relative to the top of the screen
//     top_row                buffer row shown at the top of the screen
//   Command priority: home > newline > cr > dec_col > inc_col.
module text_console_cursor
    import text_console_pkg::*;
#(
    parameter int VIS_ROWS = 30
) (
    input  logic             i_pix_clk,
    input  logic             i_reset_n,
    input  logic             inc_col,
    input  logic             dec_col,
    input  logic             cr,
    input  logic             newline,
    input  logic             home,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] phys_row,
    output logic [ROW_W-1:0] vis_row,
    output logic [ROW_W-1:0] top_row
);

    localparam logic [ROW_W-1:0] VIS_LAST = ROW_W'(VIS_ROWS - 1);

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            col      <= '0;
            phys_row <= '0;
            vis_row  <= '0;
            top_row  <= '0;
        end else if (home) begin
            col      <= '0;
            phys_row <= '0;
            vis_row  <= '0;
            top_row  <= '0;
        end else if (newline) begin
            col      <= '0;
            phys_row <= phys_row + 1'b1;
            // Scroll by moving the displayed window rather than copying rows.
            if (vis_row < VIS_LAST) begin
                vis_row <= vis_row + 1'b1;
            end else begin
                top_row <= top_row + 1'b1;
            end
        end else if (cr) begin
            col <= '0;
        end else if (dec_col) begin
            col <= col - 1'b1;
        end else if (inc_col) begin
            col <= col + 1'b1;
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// text_console_writer
//   Byte-stream front end writing into the 32x32 text buffer of the tile layer.
//   Interprets CR, LF, BS and FF; scrolls by moving the tile layer's vertical
//   offset.
//   Ports:
//     i_pix_clk, i_reset_n      clock, asynchronous active-low reset
//     i_char_valid/i_char_data  input byte, consumed when o_char_ready is high
//     o_char_ready              registered; high only in IDLE
//     o_wr_en/o_wr_addr/o_wr_data  text buffer write port, addr {row, col}
//     o_cursor_col/o_cursor_row    cursor position (physical row)
//     o_offset_y                {top_row, 3'b000}, zero-extended to 16 bits
//     o_busy                    high whenever the FSM is not in IDLE
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int         COLS           = 32,
    parameter int         ROWS           = 32,
    parameter int         VIS_ROWS       = 30,
    parameter logic [7:0] BLANK_CHAR     = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic              i_pix_clk,
    input  logic              i_reset_n,
    input  logic              i_char_valid,
    input  logic [7:0]        i_char_data,
    output logic              o_char_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic [COL_W-1:0]  o_cursor_col,
    output logic [ROW_W-1:0]  o_cursor_row,
    output logic [15:0]       o_offset_y,
    output logic              o_busy
);

    localparam logic [COL_W-1:0]  LAST_COL     = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL_CNT = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(COLS * ROWS - 1);
    localparam state_t            RESET_STATE  = CLEAR_ON_RESET ? ST_CLEAR_ALL : ST_IDLE;

    state_t            state, next_state;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic [7:0]        char_q;
    logic              latch_char;
    logic              ready_q;
    logic              accept;

    logic              cmd_inc, cmd_dec, cmd_cr, cmd_newline, cmd_home;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  phys_row;
    logic [ROW_W-1:0]  vis_row;
    logic [ROW_W-1:0]  top_row;

    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [7:0]        wr_data_c;

    text_console_cursor #(
        .VIS_ROWS(VIS_ROWS)
    ) u_cursor (
        .i_pix_clk(i_pix_clk),
        .i_reset_n(i_reset_n),
        .inc_col  (cmd_inc),
        .dec_col  (cmd_dec),
        .cr       (cmd_cr),
        .newline  (cmd_newline),
        .home     (cmd_home),
        .col      (col),
        .phys_row (phys_row),
        .vis_row  (vis_row),
        .top_row  (top_row)
    );

    // ready_q is only ever set when the FSM is entering IDLE, so it alone
    // qualifies acceptance.
    assign accept = i_char_valid & ready_q;

    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= RESET_STATE;
            cnt     <= '0;
            char_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            ready_q <= (next_state == ST_IDLE);
            if (latch_char) begin
                char_q <= i_char_data;
            end
        end
    end

    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        latch_char  = 1'b0;
        cmd_inc     = 1'b0;
        cmd_dec     = 1'b0;
        cmd_cr      = 1'b0;
        cmd_newline = 1'b0;
        cmd_home    = 1'b0;
        wr_en_c     = 1'b0;
        wr_addr_c   = '0;
        wr_data_c   = BLANK_CHAR;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (i_char_data)
                        CC_CR: cmd_cr = 1'b1;
                        CC_LF: begin
                            // Cursor moves on entry so the clear targets the new row.
                            cmd_newline = 1'b1;
                            next_state  = ST_NEWLINE_CLR;
                        end
                        CC_BS: begin
                            if (col != '0) begin
                                cmd_dec    = 1'b1;
                                next_state = ST_BACKSPACE;
                            end
                        end
                        CC_FF: next_state = ST_CLEAR_ALL;
                        default: begin
                            latch_char = 1'b1;
                            next_state = ST_PUT;
                        end
                    endcase
                end
            end

            ST_PUT: begin
                wr_en_c   = 1'b1;
                wr_addr_c = buf_addr(phys_row, col);
                wr_data_c = char_q;
                if (col == LAST_COL) begin
                    cmd_newline = 1'b1;
                    next_state  = ST_NEWLINE_CLR;
                end else begin
                    cmd_inc    = 1'b1;
                    next_state = ST_IDLE;
                end
            end

            ST_NEWLINE_CLR: begin
                wr_en_c   = 1'b1;
                wr_addr_c = buf_addr(phys_row, cnt[COL_W-1:0]);
                if (cnt == LAST_COL_CNT) begin
                    cnt_next   = '0;
                    next_state = ST_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            ST_BACKSPACE: begin
                wr_en_c    = 1'b1;
                wr_addr_c  = buf_addr(phys_row, col);
                next_state = ST_IDLE;
            end

            ST_CLEAR_ALL: begin
                wr_en_c   = 1'b1;
                wr_addr_c = cnt;
                if (cnt == LAST_ADDR) begin
                    cnt_next   = '0;
                    cmd_home   = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: next_state = ST_IDLE;
        endcase
    end

    // The reset state may be CLEAR_ALL, so the write port and busy flag are
    // masked by reset to hold them at 0 and drop them the instant reset asserts.
    assign o_wr_en      = wr_en_c & i_reset_n;
    assign o_wr_addr    = i_reset_n ? wr_addr_c : '0;
    assign o_wr_data    = i_reset_n ? wr_data_c : '0;
    assign o_busy       = (state != ST_IDLE) & i_reset_n;
    assign o_char_ready = ready_q;
    assign o_cursor_col = col;
    assign o_cursor_row = phys_row;
    assign o_offset_y   = {8'b0, top_row, 3'b000};

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
Character-stream front end that writes into the 32x32 text buffer the tile layer renders. It accepts one byte at a time over a valid/ready handshake and keeps a cursor. It interprets a small set of control codes (CR, LF, BS, FF) and scrolls by moving the tile layer's vertical offset instead of copying memory. It sits between a byte source (UART receiver or CPU port) and the write port of the text buffer RAM.

Parameters:
COLS, 32, buffer columns; power of two.
ROWS, 32, buffer rows; power of two.
VIS_ROWS, 30, rows visible on screen; must be at most ROWS.
BLANK_CHAR, 8'h20, fill byte used for clears and backspace.
CLEAR_ON_RESET, 1, when 1, the whole buffer is cleared after reset deasserts.

Ports:
i_pix_clk  in  1  sole clock.
i_reset_n  in  1  asynchronous, active-low reset.
i_char_valid  in  1  i_char_data holds a byte to consume.
i_char_data  in  8  character byte.
o_char_ready  out  1  block can accept a byte this cycle.
o_wr_en  out  1  text buffer write strobe.
o_wr_addr  out  10  write address, {phys_row[4:0], col[4:0]}.
o_wr_data  out  8  write data.
o_cursor_col  out  5  current cursor column.
o_cursor_row  out  5  current physical cursor row.
o_offset_y  out  16  vertical pixel offset for the tile layer, {top_row, 3'b000}, zero-extended.
o_busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock (i_pix_clk). Reset is asynchronous and active-low (i_reset_n).
- Reset values:
  - all outputs 0; col, phys_row, vis_row, top_row all 0.
  - FSM goes to CLEAR_ALL when CLEAR_ON_RESET=1, otherwise to IDLE.
- Handshake:
  - A byte is accepted on any cycle where i_char_valid and o_char_ready are both high.
  - o_char_ready is high only in IDLE. It is registered and never depends combinationally on i_char_valid.
  - While ready is low, a held valid is ignored and never lost.
- FSM states: IDLE, PUT, NEWLINE_CLR, BACKSPACE, CLEAR_ALL.
- IDLE, on accepted byte b:
  - b = 0x0D: col <= 0; stay in IDLE; no write.
  - b = 0x0A: go to NEWLINE_CLR.
  - b = 0x08: if col > 0, col <= col-1 and go to BACKSPACE; if col = 0, no-op.
  - b = 0x0C: go to CLEAR_ALL.
  - Any other byte: latch it and go to PUT.
- PUT (1 cycle):
  - Write the latched byte to {phys_row, col}.
  - If col = COLS-1, go to NEWLINE_CLR (auto-wrap); otherwise col <= col+1 and return to IDLE.
  - Throughput for printable bytes is one byte per 2 cycles. The write appears the cycle after acceptance.
- NEWLINE_CLR:
  - On entry: col <= 0 and phys_row <= phys_row+1 mod ROWS.
  - If vis_row < VIS_ROWS-1, vis_row increments; otherwise top_row <= top_row+1 mod ROWS (scroll).
  - Then write BLANK_CHAR to every column of the new phys_row, COLS cycles, col order 0..COLS-1.
  - Return to IDLE with col = 0.
- BACKSPACE (1 cycle): write BLANK_CHAR at {phys_row, new col}, then return to IDLE.
- CLEAR_ALL:
  - Write BLANK_CHAR to addresses 0..COLS*ROWS-1 in ascending order, one per cycle (1024 cycles).
  - Then set cursor, vis_row and top_row to 0 and return to IDLE.
- o_wr_en is high only on the cycles that perform a write listed above. o_wr_addr/o_wr_data are don't-care when o_wr_en is low.
- Width rules:
  - All row/col arithmetic is 5-bit, wrapping modulo 32.
  - o_offset_y updates in the cycle top_row changes. The tile layer may show one frame tear; this is accepted.
- Reset asserted mid-operation (including mid-CLEAR_ALL) aborts immediately. o_wr_en drops asynchronously. CLEAR_ALL restarts from address 0 after release.

Decomposition:
- Shared package text_console_pkg holds:
  - FSM state encoding.
  - Control code constants: CC_CR=8'h0D, CC_LF=8'h0A, CC_BS=8'h08, CC_FF=8'h0C.
  - Address width helper localparams: ADDR_W=10, COL_W=5, ROW_W=5.
- One natural sub-module, text_console_cursor: holds col/phys_row/vis_row/top_row, with inc_col, dec_col, newline and home commands plus scroll logic.
- The FSM and write-port mux stay in the top module.

Test Plan:
- Reset release with CLEAR_ON_RESET=1 -> o_busy high for exactly 1024 cycles; writes of 0x20 at addresses 0..1023 ascending; then o_char_ready=1 and cursor (0,0).
- Send 'A','B' with valid held high -> writes 0x41@0x000 then 0x42@0x001; ready low on alternate cycles; final col=2.
- 32 printable bytes starting at col 0, row 0 -> 32rd write at 0x01F; then 32 blank writes at 0x020..0x03F; cursor (row 1, col 0).
- 30 LFs from reset state -> the 30th sets top_row=1 and o_offset_y=16'd8; row 30 (0x3C0..0x3DF) cleared; cursor row 30.
- BS at col 3 -> blank written at {row,2}, col=2; BS at col 0 -> no write, ready returns next cycle; CR at col 5 -> col=0 with no write.
- Assert i_reset_n low at address 0x200 during FF clear -> o_wr_en drops immediately; after release, clearing restarts at address 0x000.
